data_ram: RTL

- Data-memory responder: the memory-side end of the core's data port (read enable, write enable, word address, byte select).
- Sits outside the core, opposite the MEM stage.
- Accepts one request at a time, inserts a configurable number of wait states, performs a byte-selected write or a full-word read, and signals completion with a one-cycle ready pulse.
- Storage is an internal word array.

---
 rtl/data_ram_if.sv | 34 +++
 rtl/data_ram.sv | 114 +++++++++++
 2 files changed

// File: rtl/data_ram_if.sv
// Data-port bundle between the core's MEM stage (master) and data_ram (slave).
// o_memError exists only when DATA_RAM_SEL_CHECK_EN is defined.
interface data_ram_if #(
    parameter int ADDR_WIDTH = 10
);
    logic                  i_memReadEnable;
    logic                  i_memWriteEnable;
    logic [ADDR_WIDTH-1:0] i_memAddr;
    logic [3:0]            i_memSel;
    logic [31:0]           i_memWriteData;
    logic [31:0]           o_memReadData;
    logic                  o_memReady;
`ifdef DATA_RAM_SEL_CHECK_EN
    logic                  o_memError;

    modport master (
        output i_memReadEnable, i_memWriteEnable, i_memAddr, i_memSel, i_memWriteData,
        input  o_memReadData, o_memReady, o_memError
    );
    modport slave (
        input  i_memReadEnable, i_memWriteEnable, i_memAddr, i_memSel, i_memWriteData,
        output o_memReadData, o_memReady, o_memError
    );
`else
    modport master (
        output i_memReadEnable, i_memWriteEnable, i_memAddr, i_memSel, i_memWriteData,
        input  o_memReadData, o_memReady
    );
    modport slave (
        input  i_memReadEnable, i_memWriteEnable, i_memAddr, i_memSel, i_memWriteData,
        output o_memReadData, o_memReady
    );
`endif
endinterface

// File: rtl/data_ram.sv
// Data-memory responder: one request at a time, WAIT_CYCLES wait states, one-cycle ready pulse.
// Optional DATA_RAM_SEL_CHECK_EN suppresses writes with illegal byte selects and flags o_memError.
module data_ram #(
    parameter int ADDR_WIDTH  = 10,
    parameter int WAIT_CYCLES = 1
) (
    input logic       clk,
    input logic       rst,
    data_ram_if.slave bus
);
    localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    state_t                state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic                  do_access;
    logic                  accept;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [3:0]            sel_q;
    logic [31:0]           wdata_q;
    logic                  is_write_q;
    logic [31:0]           rdata_q;
    logic                  sel_legal;
    logic [31:0]           mem [2**ADDR_WIDTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        do_access = 1'b0;
        accept    = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.i_memReadEnable || bus.i_memWriteEnable) begin
                    accept  = 1'b1;
                    cnt_d   = WAIT_LOAD;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    do_access = 1'b1;
                    state_d   = RESP;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Request fields are captured once at acceptance; later input changes are ignored.
    always_ff @(posedge clk) begin
        if (accept && !rst) begin
            addr_q     <= bus.i_memAddr;
            sel_q      <= bus.i_memSel;
            wdata_q    <= bus.i_memWriteData;
            is_write_q <= bus.i_memWriteEnable;
        end
    end

`ifdef DATA_RAM_SEL_CHECK_EN
    logic err_q;

    always_comb begin
        case (sel_q)
            4'b0001, 4'b0010, 4'b0100, 4'b1000,
            4'b0011, 4'b1100, 4'b1111: sel_legal = 1'b1;
            default:                   sel_legal = 1'b0;
        endcase
    end

    // Only set on the access edge, so it is high exactly for the RESP cycle.
    always_ff @(posedge clk) begin
        if (rst) err_q <= 1'b0;
        else     err_q <= do_access && is_write_q && !sel_legal;
    end

    assign bus.o_memError = err_q;
`else
    assign sel_legal = 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (do_access && is_write_q && sel_legal && !rst) begin
            for (int unsigned i = 0; i < 4; i++) begin
                if (sel_q[i]) mem[addr_q][8*i +: 8] <= wdata_q[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst)                          rdata_q <= '0;
        else if (do_access && !is_write_q) rdata_q <= mem[addr_q];
    end

    assign bus.o_memReadData = rdata_q;
    assign bus.o_memReady    = (state_q == RESP);
endmodule
